// File: rtl/pipe_chain_pkg.sv
// Shared defaults and helpers for the elastic pipeline-register chain.
// The payload carries the pc in a fixed low field for the diff-test port.
package pipe_chain_pkg;

    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_STAGES = 4;
    localparam bit          DEF_SKID   = 1'b1;

    localparam int unsigned PC_LSB = 0;
    localparam int unsigned PC_MSB = 63;

    // Ceiling log2; the occupancy port must hold STAGES slots plus the skid slot.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid/data register of the chain: flush beats load, load beats hold.
// valid_next is exported so the parent can count occupancy without re-deriving it.
module pipe_slot
    import pipe_chain_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic              valid_next,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_next = valid_q;
        data_d     = data_q;
        if (flush) begin
            valid_next = 1'b0;
        end else if (load) begin
            valid_next = in_valid;
            // Payload only moves with a real item so bubbles leave it untouched.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_next;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ysyx_22040175_pipe_chain.sv
// Elastic chain of STAGES valid/ready register slots with per-slot flush, optional
// input skid slot (registered in_ready), occupancy count and saturating stall counter.
module ysyx_22040175_pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int unsigned  DATA_W = DEF_DATA_W,
    parameter int unsigned  STAGES = DEF_STAGES,
    parameter bit           SKID   = DEF_SKID,
    localparam int unsigned OCC_W  = clog2(STAGES + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [63:0]       out_pc,
    output logic              out_fire,
    input  logic [STAGES-1:0] flush,
    output logic [OCC_W-1:0]  occupancy,
    output logic [31:0]       bp_cycles
);

    logic [STAGES-1:0] v, v_next;
    logic [DATA_W-1:0] d [STAGES];
    logic [STAGES-1:0] up_valid;
    logic [DATA_W-1:0] up_data [STAGES];
    logic [STAGES:0]   take;
    logic              sv, sv_next;
    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [31:0]       bp_q, bp_d;
    logic              stall;

    // Ready ripples back from the output: a slot advances when empty or when its
    // successor takes, and a flushed slot refuses so its predecessor holds.
    always_comb begin
        take         = '0;
        take[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            take[i] = (~v[i] | take[i+1]) & ~flush[i];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign up_valid[i] = head_valid;
            assign up_data[i]  = head_data;
        end else begin : g_link
            assign up_valid[i] = v[i-1];
            assign up_data[i]  = d[i-1];
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (take[i]),
            .flush      (flush[i]),
            .in_valid   (up_valid[i]),
            .in_data    (up_data[i]),
            .valid      (v[i]),
            .valid_next (v_next[i]),
            .data       (d[i])
        );
    end

    if (SKID) begin : g_skid
        logic [DATA_W-1:0] skid_d;
        logic              skid_load;

        // Empty skid captures an input that slot 0 cannot take; a full skid
        // empties (loads a bubble) once slot 0 takes from it.
        assign skid_load = sv ? take[0] : (in_valid & ~take[0]);

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_skid (
            .clk        (clk),
            .rst        (rst),
            .load       (skid_load),
            .flush      (flush[0]),
            .in_valid   (~sv),
            .in_data    (in_data),
            .valid      (sv),
            .valid_next (sv_next),
            .data       (skid_d)
        );

        assign head_valid = sv | in_valid;
        assign head_data  = sv ? skid_d : in_data;
        assign in_ready   = ~sv;
    end else begin : g_no_skid
        assign sv         = 1'b0;
        assign sv_next    = 1'b0;
        assign head_valid = in_valid;
        assign head_data  = in_data;
        assign in_ready   = take[0];
    end

    // Count from next state so the registered value matches the slots it describes.
    always_comb begin
        occ_d = OCC_W'(sv_next);
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(v_next[i]);
        end
    end

    assign stall = out_valid & ~out_ready;
    assign bp_d  = (stall && (bp_q != 32'hFFFF_FFFF)) ? bp_q + 32'd1 : bp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
            bp_q  <= '0;
        end else begin
            occ_q <= occ_d;
            bp_q  <= bp_d;
        end
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign out_pc    = out_data[PC_MSB:PC_LSB];
    // A flush of the last slot wins over a consuming downstream.
    assign out_fire  = out_valid & out_ready & ~flush[STAGES-1];
    assign occupancy = occ_q;
    assign bp_cycles = bp_q;

endmodule
